ko_stock_tracker: RTL and testbench

- Sits downstream of the physics and damage coprocessor outputs inside the MMIO coprocessor complex.
- Consumes each player's packed position and per-hit damage amount.
- Keeps per-player accumulated damage and remaining lives (stocks), detects blast-zone KOs and times respawns.
- Drives the damage/lives words read by the processor and VGA coprocessors, plus respawn and game-over status.

---
 rtl/ko_stock_tracker_if.sv | 30 +++
 rtl/ko_stock_tracker.sv | 179 +++++++++++++++++
 tb/tb_ko_stock_tracker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ko_stock_tracker_if.sv
// Bus between the physics/damage coprocessors and the KO/stock tracker:
// player positions and hit amounts in, damage/lives/status words out.
`timescale 1ns/1ps
interface ko_stock_tracker_if;
    logic [31:0] pos1;
    logic [31:0] pos2;
    logic [31:0] hit1;
    logic [31:0] hit2;
    logic [31:0] damage1;
    logic [31:0] damage2;
    logic [31:0] lives1;
    logic [31:0] lives2;
    logic        respawn1;
    logic        respawn2;
    logic [1:0]  freeze;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output pos1, pos2, hit1, hit2,
        input  damage1, damage2, lives1, lives2,
        input  respawn1, respawn2, freeze, game_over, winner
    );

    modport slave (
        input  pos1, pos2, hit1, hit2,
        output damage1, damage2, lives1, lives2,
        output respawn1, respawn2, freeze, game_over, winner
    );
endinterface

// File: rtl/ko_stock_tracker.sv
// Per-player damage/stock bookkeeping with blast-zone KO detection, respawn
// timing and a global play/game-over FSM. All outputs come straight from flops.
`timescale 1ns/1ps
module ko_stock_tracker #(
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned MAX_DAMAGE     = 999,
    parameter logic [15:0] BLAST_XMIN     = 16'h0010,
    parameter logic [15:0] BLAST_XMAX     = 16'h0400,
    parameter logic [15:0] BLAST_YMAX     = 16'h0300,
    parameter int unsigned RESPAWN_CYCLES = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    ko_stock_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        P_ALIVE   = 2'd0,
        P_KO_WAIT = 2'd1,
        P_RESPAWN = 2'd2,
        P_OUT     = 2'd3
    } pstate_t;

    typedef enum logic {
        G_PLAY      = 1'b0,
        G_GAME_OVER = 1'b1
    } gstate_t;

    localparam logic [15:0] MAX_DMG_L     = 16'(MAX_DAMAGE);
    localparam logic [7:0]  START_LIVES_L = 8'(START_LIVES);
    localparam logic [31:0] RESPAWN_LAST  = 32'(RESPAWN_CYCLES - 1);

    // 17-bit sum so a large hit cannot wrap before the ceiling is applied.
    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [15:0] amt);
        logic [16:0] sum;
        sum = {1'b0, acc} + {1'b0, amt};
        if (sum > {1'b0, MAX_DMG_L}) begin
            sat_add = MAX_DMG_L;
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

    function automatic logic in_blast(input logic [31:0] pos);
        in_blast = (pos[31:16] < BLAST_XMIN) || (pos[31:16] > BLAST_XMAX) ||
                   (pos[15:0] > BLAST_YMAX);
    endfunction

    logic [31:0] pos_s       [2];
    logic [15:0] hit_s       [2];
    logic [1:0]  hit_edge_s;
    pstate_t     pst_r       [2];
    pstate_t     pst_nxt_s   [2];
    logic [15:0] dmg_r       [2];
    logic [15:0] dmg_nxt_s   [2];
    logic [7:0]  lives_r     [2];
    logic [7:0]  lives_nxt_s [2];
    logic [31:0] cnt_r       [2];
    logic [31:0] cnt_nxt_s   [2];
    logic [1:0]  hit_nz_r;
    logic [1:0]  respawn_r;
    logic [1:0]  freeze_r;
    gstate_t     gst_r;
    gstate_t     gst_nxt_s;
    logic        game_over_r;
    logic [1:0]  winner_r;
    logic [1:0]  winner_nxt_s;
    logic        unused_hit_hi_s;

    // Flatten the two players onto indexable arrays.
    always_comb begin
        pos_s[0] = bus.pos1;
        pos_s[1] = bus.pos2;
        hit_s[0] = bus.hit1[15:0];
        hit_s[1] = bus.hit2[15:0];
    end

    assign unused_hit_hi_s = ^{bus.hit1[31:16], bus.hit2[31:16]};

    // Per-player FSM: KO beats a same-cycle hit; everything holds once the game is over.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pst_nxt_s[p]   = pst_r[p];
            dmg_nxt_s[p]   = dmg_r[p];
            lives_nxt_s[p] = lives_r[p];
            cnt_nxt_s[p]   = cnt_r[p];
            hit_edge_s[p]  = (hit_s[p] != 16'h0000) && !hit_nz_r[p];
            if (gst_r == G_GAME_OVER) begin
                pst_nxt_s[p] = pst_r[p];
            end else begin
                case (pst_r[p])
                    P_ALIVE: begin
                        if (in_blast(pos_s[p])) begin
                            lives_nxt_s[p] = (lives_r[p] != 8'd0) ? (lives_r[p] - 8'd1) : 8'd0;
                            dmg_nxt_s[p]   = 16'h0000;
                            cnt_nxt_s[p]   = 32'd0;
                            pst_nxt_s[p]   = (lives_r[p] <= 8'd1) ? P_OUT : P_KO_WAIT;
                        end else if (hit_edge_s[p]) begin
                            dmg_nxt_s[p] = sat_add(dmg_r[p], hit_s[p]);
                        end else begin
                            dmg_nxt_s[p] = dmg_r[p];
                        end
                    end
                    P_KO_WAIT: begin
                        if (cnt_r[p] == RESPAWN_LAST) begin
                            pst_nxt_s[p] = P_RESPAWN;
                        end else begin
                            cnt_nxt_s[p] = cnt_r[p] + 32'd1;
                        end
                    end
                    P_RESPAWN: pst_nxt_s[p] = P_ALIVE;
                    P_OUT:     pst_nxt_s[p] = P_OUT;
                    default:   pst_nxt_s[p] = P_ALIVE;
                endcase
            end
        end
    end

    // Global FSM: winner bits are {P1 out, P2 out}, so 1=P1 wins, 2=P2 wins, 3=draw.
    always_comb begin
        gst_nxt_s    = gst_r;
        winner_nxt_s = winner_r;
        case (gst_r)
            G_PLAY: begin
                if ((pst_r[0] == P_OUT) || (pst_r[1] == P_OUT)) begin
                    gst_nxt_s    = G_GAME_OVER;
                    winner_nxt_s = {pst_r[0] == P_OUT, pst_r[1] == P_OUT};
                end else begin
                    gst_nxt_s = G_PLAY;
                end
            end
            G_GAME_OVER: gst_nxt_s = G_GAME_OVER;
            default:     gst_nxt_s = G_PLAY;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                pst_r[p]   <= P_ALIVE;
                dmg_r[p]   <= 16'h0000;
                lives_r[p] <= START_LIVES_L;
                cnt_r[p]   <= 32'd0;
            end
            hit_nz_r    <= 2'b00;
            respawn_r   <= 2'b00;
            freeze_r    <= 2'b00;
            gst_r       <= G_PLAY;
            game_over_r <= 1'b0;
            winner_r    <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                pst_r[p]     <= pst_nxt_s[p];
                dmg_r[p]     <= dmg_nxt_s[p];
                lives_r[p]   <= lives_nxt_s[p];
                cnt_r[p]     <= cnt_nxt_s[p];
                hit_nz_r[p]  <= (hit_s[p] != 16'h0000);
                // Pulse only on entry so a RESPAWN frozen by game-over cannot stick high.
                respawn_r[p] <= (pst_nxt_s[p] == P_RESPAWN) && (pst_r[p] != P_RESPAWN);
                freeze_r[p]  <= (pst_nxt_s[p] != P_ALIVE);
            end
            gst_r       <= gst_nxt_s;
            game_over_r <= (gst_nxt_s == G_GAME_OVER);
            winner_r    <= winner_nxt_s;
        end
    end

    assign bus.damage1   = {16'h0000, dmg_r[0]};
    assign bus.damage2   = {16'h0000, dmg_r[1]};
    assign bus.lives1    = {24'h000000, lives_r[0]};
    assign bus.lives2    = {24'h000000, lives_r[1]};
    assign bus.respawn1  = respawn_r[0];
    assign bus.respawn2  = respawn_r[1];
    assign bus.freeze    = freeze_r;
    assign bus.game_over = game_over_r;
    assign bus.winner    = winner_r;

endmodule

// File: tb/tb_ko_stock_tracker.sv
// Directed bench for ko_stock_tracker: a vector table for reset/hit/boundary
// behaviour, then hand-written KO, respawn, game-over and reset sequences.
`timescale 1ns/1ps
module tb_ko_stock_tracker;

    localparam logic [31:0] SAFE    = 32'h0100_0100;
    localparam logic [31:0] OUT_POS = 32'h0005_00FA;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ko_stock_tracker_if bus();

    ko_stock_tracker #(
        .START_LIVES(3),
        .MAX_DAMAGE(999),
        .BLAST_XMIN(16'h0010),
        .BLAST_XMAX(16'h0400),
        .BLAST_YMAX(16'h0300),
        .RESPAWN_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [31:0] p1, p2, h1, h2;
        logic [31:0] d1, d2, l1, l2;
        logic [1:0]  rsp, frz;
        logic        go;
        logic [1:0]  win;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [31:0] p1, input logic [31:0] p2,
                                input logic [31:0] h1, input logic [31:0] h2,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] l1, input logic [31:0] l2,
                                input logic [1:0] rsp, input logic [1:0] frz,
                                input logic go, input logic [1:0] win);
        vec_t v;
        v.rst = rst; v.p1 = p1; v.p2 = p2; v.h1 = h1; v.h2 = h2;
        v.d1 = d1; v.d2 = d2; v.l1 = l1; v.l2 = l2;
        v.rsp = rsp; v.frz = frz; v.go = go; v.win = win;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic apply(input logic rst, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] h1, input logic [31:0] h2);
        @(negedge clock);
        reset    = rst;
        bus.pos1 = p1;
        bus.pos2 = p2;
        bus.hit1 = h1;
        bus.hit2 = h2;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] l1, input logic [31:0] l2,
                              input logic [1:0] rsp, input logic [1:0] frz,
                              input logic go, input logic [1:0] win);
        chk({tag, ".damage1"}, bus.damage1, d1);
        chk({tag, ".damage2"}, bus.damage2, d2);
        chk({tag, ".lives1"}, bus.lives1, l1);
        chk({tag, ".lives2"}, bus.lives2, l2);
        chk({tag, ".respawn"}, {30'd0, bus.respawn2, bus.respawn1}, {30'd0, rsp});
        chk({tag, ".freeze"}, {30'd0, bus.freeze}, {30'd0, frz});
        chk({tag, ".game_over"}, {31'd0, bus.game_over}, {31'd0, go});
        chk({tag, ".winner"}, {30'd0, bus.winner}, {30'd0, win});
    endtask

    // One KO cycle for the selected players, then five safe cycles (respawn + back to ALIVE).
    task automatic kill(input logic k1, input logic k2);
        apply(1'b0, k1 ? OUT_POS : SAFE, k2 ? OUT_POS : SAFE, 32'd0, 32'd0);
        repeat (5) apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
    endtask

    initial begin
        bus.pos1 = SAFE;
        bus.pos2 = SAFE;
        bus.hit1 = 32'd0;
        bus.hit2 = 32'd0;

        //                 rst   pos1           pos2           hit1      hit2              d1       d2        l1     l2     rsp    frz    go    win
        tbl.push_back(mk(1'b1, SAFE,          SAFE,          32'd0,  32'd0,            32'd0,  32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd12, 32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd12, 32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd12, 32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd12, 32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd12, 32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd12, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd7,  32'd0,            32'd19, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd19, 32'd0,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd5,            32'd19, 32'd5,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd9,            32'd19, 32'd5,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd19, 32'd5,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'h0001_0000,    32'd19, 32'd5,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd19, 32'd5,   32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'h0000_FFFF,    32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 32'h0010_0100, SAFE,          32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 32'h0400_0100, SAFE,          32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 32'h0100_0300, SAFE,          32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          32'h0400_0300, 32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, SAFE,          SAFE,          32'd0,  32'd0,            32'd19, 32'd999, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].p1, tbl[i].p2, tbl[i].h1, tbl[i].h2);
            expect_all($sformatf("vec%0d", i), tbl[i].d1, tbl[i].d2, tbl[i].l1, tbl[i].l2,
                       tbl[i].rsp, tbl[i].frz, tbl[i].go, tbl[i].win);
        end

        // KO with a same-cycle hit, then a hit during KO_WAIT, then the respawn pulse.
        apply(1'b0, OUT_POS, SAFE, 32'd50, 32'd0);
        expect_all("ko_a0", 32'd0, 32'd999, 32'd2, 32'd3, 2'b00, 2'b01, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("ko_a1", 32'd0, 32'd999, 32'd2, 32'd3, 2'b00, 2'b01, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd30, 32'd0);
        expect_all("ko_a2", 32'd0, 32'd999, 32'd2, 32'd3, 2'b00, 2'b01, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("ko_a3", 32'd0, 32'd999, 32'd2, 32'd3, 2'b00, 2'b01, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("ko_a4", 32'd0, 32'd999, 32'd2, 32'd3, 2'b01, 2'b01, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("ko_a5", 32'd0, 32'd999, 32'd2, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);

        // P1 saturation after respawn: 990 then +20 caps at 999.
        apply(1'b0, SAFE, SAFE, 32'd990, 32'd0);
        expect_all("sat0", 32'd990, 32'd999, 32'd2, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        apply(1'b0, SAFE, SAFE, 32'd20, 32'd0);
        expect_all("sat1", 32'd999, 32'd999, 32'd2, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);

        // x = BLAST_XMAX+1 is a KO.
        apply(1'b0, 32'h0401_0100, SAFE, 32'd0, 32'd0);
        expect_all("ko_xmax1", 32'd0, 32'd999, 32'd1, 32'd3, 2'b00, 2'b01, 1'b0, 2'd0);
        repeat (5) apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("ko_b_back", 32'd0, 32'd999, 32'd1, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd25, 32'd0);
        expect_all("hit_b", 32'd25, 32'd999, 32'd1, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);

        // Reset in the middle of a KO_WAIT countdown.
        apply(1'b0, SAFE, OUT_POS, 32'd0, 32'd0);
        expect_all("ko_c", 32'd25, 32'd0, 32'd1, 32'd2, 2'b00, 2'b10, 1'b0, 2'd0);
        repeat (2) apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        apply(1'b1, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("rst_mid", 32'd0, 32'd0, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
            expect_all($sformatf("post_rst%0d", k), 32'd0, 32'd0, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        end

        // P2 KO'd three times: P1 wins, then P1 hits and KOs are ignored.
        kill(1'b0, 1'b1);
        expect_all("p2_ko1", 32'd0, 32'd0, 32'd3, 32'd2, 2'b00, 2'b00, 1'b0, 2'd0);
        kill(1'b0, 1'b1);
        expect_all("p2_ko2", 32'd0, 32'd0, 32'd3, 32'd1, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, SAFE, OUT_POS, 32'd0, 32'd0);
        expect_all("p2_out", 32'd0, 32'd0, 32'd3, 32'd0, 2'b00, 2'b10, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("go_p1", 32'd0, 32'd0, 32'd3, 32'd0, 2'b00, 2'b10, 1'b1, 2'd1);
        apply(1'b0, SAFE, SAFE, 32'd40, 32'd0);
        expect_all("go_hit", 32'd0, 32'd0, 32'd3, 32'd0, 2'b00, 2'b10, 1'b1, 2'd1);
        apply(1'b0, OUT_POS, SAFE, 32'd0, 32'd0);
        expect_all("go_ko", 32'd0, 32'd0, 32'd3, 32'd0, 2'b00, 2'b10, 1'b1, 2'd1);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("go_hold", 32'd0, 32'd0, 32'd3, 32'd0, 2'b00, 2'b10, 1'b1, 2'd1);

        // Restart, bring both players to one life, then KO both together: draw.
        apply(1'b1, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("rst_go", 32'd0, 32'd0, 32'd3, 32'd3, 2'b00, 2'b00, 1'b0, 2'd0);
        kill(1'b1, 1'b1);
        expect_all("both_ko1", 32'd0, 32'd0, 32'd2, 32'd2, 2'b00, 2'b00, 1'b0, 2'd0);
        kill(1'b1, 1'b1);
        expect_all("both_ko2", 32'd0, 32'd0, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 2'd0);
        apply(1'b0, OUT_POS, OUT_POS, 32'd0, 32'd0);
        expect_all("both_out", 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11, 1'b0, 2'd0);
        apply(1'b0, SAFE, SAFE, 32'd0, 32'd0);
        expect_all("draw", 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b11, 1'b1, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
